// File: rtl/dot2_mac_if.sv
// Operand/result bundle for the dot2_mac kernel.
// The CLR line is present only when DOT2_CLR_EN is defined.
interface dot2_mac_if #(parameter int WIDTH = 8);
  logic               START;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH:0]   OUT;
  logic               OUT_STROBE;
`ifdef DOT2_CLR_EN
  logic               CLR;

  modport master (output START, A, B, CLR, input OUT, OUT_STROBE);
  modport slave  (input START, A, B, CLR, output OUT, OUT_STROBE);
`else
  modport master (output START, A, B, input OUT, OUT_STROBE);
  modport slave  (input START, A, B, output OUT, OUT_STROBE);
`endif
endinterface

// File: rtl/dot2_mac.sv
// Signed two-term dot product OUT = A0*B0 + A1*B1, one result every 3 cycles.
// Optional synchronous clear is enabled with DOT2_CLR_EN.
module dot2_mac #(
  parameter int WIDTH = 8
) (
  input  logic       CLK,
  input  logic       NRST,
  dot2_mac_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    OUTS = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      en_r0, en_r1, en_out;
  logic                      clr;
  logic signed [2*WIDTH-1:0] prod, r0_q, r1_q;
  logic signed [2*WIDTH:0]   sum, out_q;
  logic                      strobe_q;

`ifdef DOT2_CLR_EN
  assign clr = bus.CLR;
`else
  assign clr = 1'b0;
`endif

  assign prod = $signed(bus.A) * $signed(bus.B);
  // One guard bit absorbs the only overflow case, (-2^(W-1))^2 twice.
  assign sum  = {r0_q[2*WIDTH-1], r0_q} + {r1_q[2*WIDTH-1], r1_q};

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)    state_q <= IDLE;
    else if (clr) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    en_r0   = 1'b0;
    en_r1   = 1'b0;
    en_out  = 1'b0;
    case (state_q)
      IDLE: state_d = bus.START ? MUL1 : IDLE;
      MUL1: begin
        en_r0   = 1'b1;
        state_d = MUL2;
      end
      MUL2: begin
        en_r0   = 1'b1;
        en_r1   = 1'b1;
        state_d = OUTS;
      end
      OUTS: begin
        en_out  = 1'b1;
        state_d = MUL1;
      end
      default: state_d = IDLE;
    endcase
  end

  // OUT deliberately survives a clear; only reset zeroes it.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r0_q     <= '0;
      r1_q     <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else if (clr) begin
      r0_q     <= '0;
      r1_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      if (en_r0)  r0_q  <= prod;
      if (en_r1)  r1_q  <= r0_q;
      if (en_out) out_q <= sum;
      strobe_q <= en_out;
    end
  end

  assign bus.OUT        = out_q;
  assign bus.OUT_STROBE = strobe_q;

endmodule

// File: tb/tb_dot2_mac.sv
// Bench for dot2_mac: table-driven pairs streamed through a timed scoreboard,
// plus reset-abort and (with DOT2_CLR_EN) clear-abort sequences.
module tb_dot2_mac;
  localparam int W = 8;

  typedef struct {
    int a0;
    int b0;
    int a1;
    int b1;
    int exp;
  } vec_t;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic CLK  = 1'b0;
  logic NRST = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_out = 0;
  exp_t sb[$];
  vec_t tbl[12];

  dot2_mac_if #(.WIDTH(W)) bus();

  dot2_mac #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Every cycle: strobe must match the scoreboard exactly, OUT must hold between strobes.
  always @(negedge CLK) begin
    logic signed [2*W:0] got;
    bit                  exp_stb;
    got = bus.OUT;
    if (!NRST) begin
      exp_out = 0;
      check("reset_out", int'(got), 0);
      check("reset_strobe", int'(bus.OUT_STROBE), 0);
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_strobe: got none expected %0d at cycle %0d", sb[0].val, sb[0].due);
        sb.delete(0);
      end
      exp_stb = (sb.size() > 0) && (sb[0].due == cyc);
      check("strobe", int'(bus.OUT_STROBE), int'(exp_stb));
      if (exp_stb) begin
        exp_out = sb[0].val;
        sb.delete(0);
      end
      check("out", int'(got), exp_out);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(int a, int b);
    bus.A = W'(a);
    bus.B = W'(b);
  endtask

  // Called in the cycle before the MUL1 sampling edge; covers MUL1, MUL2, OUTS.
  task automatic run_pair(vec_t v);
    drive(v.a0, v.b0);
    tick();
    drive(v.a1, v.b1);
    sb.push_back('{v.exp, cyc + 2});
    tick();
    drive(int'($urandom), int'($urandom));
    tick();
  endtask

  task automatic start_pulse();
    bus.START = 1'b1;
    drive(int'($urandom), int'($urandom));
    tick();
    bus.START = 1'b0;
  endtask

  initial begin
    tbl[0] = '{3, 4, 5, -6, -18};
    tbl[1] = '{-128, -128, -128, -128, 32768};
    tbl[2] = '{127, -128, 0, 5, -16256};
    tbl[3] = '{-1, -1, -1, -1, 2};
    tbl[4] = '{0, 0, 0, 0, 0};
    tbl[5] = '{127, 127, 127, 127, 32258};
    tbl[6] = '{-128, 127, -128, 127, -32512};
    tbl[7] = '{1, -1, 2, 3, 5};
    for (int i = 8; i < 12; i++) begin
      tbl[i].a0  = int'($urandom_range(0, 255)) - 128;
      tbl[i].b0  = int'($urandom_range(0, 255)) - 128;
      tbl[i].a1  = int'($urandom_range(0, 255)) - 128;
      tbl[i].b1  = int'($urandom_range(0, 255)) - 128;
      tbl[i].exp = tbl[i].a0 * tbl[i].b0 + tbl[i].a1 * tbl[i].b1;
    end

    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
`ifdef DOT2_CLR_EN
    bus.CLR   = 1'b0;
`endif

    // Reset, then idle with START low and noisy operands: no strobe allowed.
    repeat (3) tick();
    NRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(int'($urandom), int'($urandom));
      tick();
    end

    // One START, then every table pair back-to-back.
    start_pulse();
    for (int i = 0; i < 12; i++) run_pair(tbl[i]);

    // Abort mid-pair: reset asserted while in MUL2.
    drive(7, 7);
    tick();
    drive(9, 9);
    #2;
    NRST = 1'b0;
    tick();
    tick();
    NRST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(int'($urandom), int'($urandom));
      tick();
    end

    // Restart after reset.
    start_pulse();
    run_pair(tbl[0]);

`ifdef DOT2_CLR_EN
    // Clear in MUL2: back to IDLE, no strobe, OUT keeps -18.
    drive(11, 11);
    tick();
    drive(12, 12);
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(int'($urandom), int'($urandom));
      tick();
    end
    start_pulse();
    run_pair(tbl[2]);
`endif

    // Let the last strobe be seen, then stop the free-running FSM with reset.
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
    end
    NRST = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
